// File: rtl/mac_operand_sign_pipe.sv
// mac_operand_sign_pipe
//
// Two-stage operand pre-conditioner that sits in front of the MAC array.
// The A and B operands each arrive as NUM_LANES packed lanes, with lane 0 at
// the LSBs. Each transaction also carries its own config word. The config
// groups neighbouring lanes into wider operands: 1, 2, 4 or more lanes per
// group, and the groups are aligned. For a signed group the block outputs its
// unsigned magnitude. It also outputs a product-sign flag for every lane, and
// the result re-negation stage uses that flag later.
//
// Config word: the MSB selects signed operation. The low MODE_WIDTH bits hold
// log2(lanes per group). A mode value above log2(NUM_LANES) puts all lanes in
// one group.
//
// Stage 1 registers the operands and the config. It also registers the
// per-group sign of A and of B, taken from the MSB of each group's top lane.
// Stage 2 registers the conditionally negated magnitudes and the product
// sign. The config moves down the pipeline with its own data.
//
// Optional build macro:
//   MAC_NEG_ZERO_SIGN_EN - when defined, out_neg is cleared for any group
//                          where either final magnitude is zero. The result
//                          stage then never produces a negative zero.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_cfg, in_a, in_b  transaction config and packed operand lanes
//   out_valid/out_ready output handshake
//   out_cfg             config carried with the output data
//   out_a_mag/out_b_mag unsigned group magnitudes
//   out_neg             per-lane product-negative flag
//   busy                high while either stage holds valid data
module mac_operand_sign_pipe #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned MODE_WIDTH = 2,
  parameter int unsigned CONF_WIDTH = MODE_WIDTH + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CONF_WIDTH-1:0]           in_cfg,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_a,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CONF_WIDTH-1:0]           out_cfg,
  output logic [NUM_LANES*LANE_WIDTH-1:0] out_a_mag,
  output logic [NUM_LANES*LANE_WIDTH-1:0] out_b_mag,
  output logic [NUM_LANES-1:0]            out_neg,
  output logic                            busy
);

  localparam int unsigned DataWidth = NUM_LANES * LANE_WIDTH;
  localparam int unsigned LogLanes  = $clog2(NUM_LANES);

  // log2 of the group size, clamped so that out-of-range modes give one group.
  function automatic int unsigned group_log(input logic [CONF_WIDTH-1:0] cfg);
    int unsigned mode;
    mode = 32'(cfg[MODE_WIDTH-1:0]);
    return (mode > LogLanes) ? LogLanes : mode;
  endfunction

  // Per-lane copy of the sign of the lane's group. The sign is the MSB of the
  // group's top lane, and it counts only for signed configs.
  function automatic logic [NUM_LANES-1:0] group_signs(input logic [CONF_WIDTH-1:0] cfg,
                                                       input logic [DataWidth-1:0]  data);
    logic [NUM_LANES-1:0] signs;
    int unsigned          gl;
    gl    = group_log(cfg);
    signs = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      for (int unsigned j = 0; j < NUM_LANES; j++) begin
        // j is the top lane of i's group: same group, and j+1 starts a new one
        if (((j >> gl) == (i >> gl)) && (((j + 1) >> gl) != (j >> gl))) begin
          signs[i] = cfg[CONF_WIDTH-1] & data[j*LANE_WIDTH + LANE_WIDTH - 1];
        end
      end
    end
    return signs;
  endfunction

  // Two's complement of every group whose sign is set. The group is negated
  // with invert-and-add-one, and the carry ripples lane by lane. The lowest
  // lane of each group injects the +1. This restarts the chain, so a carry
  // never leaks into the next group.
  function automatic logic [DataWidth-1:0] magnitude(input logic [DataWidth-1:0] data,
                                                     input logic [NUM_LANES-1:0] signs,
                                                     input int unsigned          gl);
    logic [DataWidth-1:0]  mag;
    logic [LANE_WIDTH:0]   sum;
    logic                  carry;
    mag   = '0;
    carry = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (((i >> gl) << gl) == i) begin
        carry = 1'b1;
      end
      sum = {1'b0, ~data[i*LANE_WIDTH +: LANE_WIDTH]} + {{LANE_WIDTH{1'b0}}, carry};
      if (signs[i]) begin
        mag[i*LANE_WIDTH +: LANE_WIDTH] = sum[LANE_WIDTH-1:0];
        carry                           = sum[LANE_WIDTH];
      end else begin
        mag[i*LANE_WIDTH +: LANE_WIDTH] = data[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
    return mag;
  endfunction

`ifdef MAC_NEG_ZERO_SIGN_EN
  // Per-lane flag: every lane of this lane's group is zero.
  function automatic logic [NUM_LANES-1:0] group_zero(input logic [DataWidth-1:0] data,
                                                      input int unsigned          gl);
    logic [NUM_LANES-1:0] zero;
    zero = '1;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      for (int unsigned j = 0; j < NUM_LANES; j++) begin
        if (((j >> gl) == (i >> gl)) && (data[j*LANE_WIDTH +: LANE_WIDTH] != '0)) begin
          zero[i] = 1'b0;
        end
      end
    end
    return zero;
  endfunction
`endif

  // Stage 1 state
  logic                  s1_valid_q, s1_valid_d;
  logic [CONF_WIDTH-1:0] s1_cfg_q, s1_cfg_d;
  logic [DataWidth-1:0]  s1_a_q, s1_a_d;
  logic [DataWidth-1:0]  s1_b_q, s1_b_d;
  logic [NUM_LANES-1:0]  s1_sign_a_q, s1_sign_a_d;
  logic [NUM_LANES-1:0]  s1_sign_b_q, s1_sign_b_d;

  // Stage 2 state (drives the outputs)
  logic                  s2_valid_q, s2_valid_d;
  logic [CONF_WIDTH-1:0] s2_cfg_q, s2_cfg_d;
  logic [DataWidth-1:0]  s2_a_mag_q, s2_a_mag_d;
  logic [DataWidth-1:0]  s2_b_mag_q, s2_b_mag_d;
  logic [NUM_LANES-1:0]  s2_neg_q, s2_neg_d;

  logic                  s2_ready;
  logic                  in_accept;
  int unsigned           s1_gl;
  logic [DataWidth-1:0]  s1_a_mag, s1_b_mag;
  logic [NUM_LANES-1:0]  s1_neg;

  assign s2_ready  = ~s2_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | s2_ready;
  assign in_accept = in_valid & in_ready;

  assign s1_gl    = group_log(s1_cfg_q);
  assign s1_a_mag = magnitude(s1_a_q, s1_sign_a_q, s1_gl);
  assign s1_b_mag = magnitude(s1_b_q, s1_sign_b_q, s1_gl);

`ifdef MAC_NEG_ZERO_SIGN_EN
  assign s1_neg = (s1_sign_a_q ^ s1_sign_b_q)
                & ~group_zero(s1_a_mag, s1_gl) & ~group_zero(s1_b_mag, s1_gl);
`else
  assign s1_neg = s1_sign_a_q ^ s1_sign_b_q;
`endif

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_cfg_d    = s1_cfg_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_sign_a_d = s1_sign_a_q;
    s1_sign_b_d = s1_sign_b_q;
    s2_valid_d  = s2_valid_q;
    s2_cfg_d    = s2_cfg_q;
    s2_a_mag_d  = s2_a_mag_q;
    s2_b_mag_d  = s2_b_mag_q;
    s2_neg_d    = s2_neg_q;

    // in_ready means stage 1 is empty or is moving into stage 2 this cycle.
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_accept) begin
      s1_cfg_d    = in_cfg;
      s1_a_d      = in_a;
      s1_b_d      = in_b;
      s1_sign_a_d = group_signs(in_cfg, in_a);
      s1_sign_b_d = group_signs(in_cfg, in_b);
    end

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_cfg_d   = s1_cfg_q;
        s2_a_mag_d = s1_a_mag;
        s2_b_mag_d = s1_b_mag;
        s2_neg_d   = s1_neg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_cfg_q    <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sign_a_q <= '0;
      s1_sign_b_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_cfg_q    <= '0;
      s2_a_mag_q  <= '0;
      s2_b_mag_q  <= '0;
      s2_neg_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cfg_q    <= s1_cfg_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_sign_a_q <= s1_sign_a_d;
      s1_sign_b_q <= s1_sign_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_cfg_q    <= s2_cfg_d;
      s2_a_mag_q  <= s2_a_mag_d;
      s2_b_mag_q  <= s2_b_mag_d;
      s2_neg_q    <= s2_neg_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_cfg   = s2_cfg_q;
  assign out_a_mag = s2_a_mag_q;
  assign out_b_mag = s2_b_mag_q;
  assign out_neg   = s2_neg_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_mac_operand_sign_pipe.sv
// Self-checking bench for mac_operand_sign_pipe (default parameters: 4 lanes of 8 bits).
// It covers directed table vectors, a backpressure run, a mid-flight reset, and
// randomised traffic that is checked against a group-arithmetic reference model.
module tb_mac_operand_sign_pipe;

  localparam int unsigned NL = 4;
  localparam int unsigned LW = 8;
  localparam int unsigned DW = NL * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_cfg;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_cfg;
  logic [DW-1:0] out_a_mag;
  logic [DW-1:0] out_b_mag;
  logic [NL-1:0] out_neg;
  logic          busy;

  mac_operand_sign_pipe #(
    .NUM_LANES  (NL),
    .LANE_WIDTH (LW),
    .MODE_WIDTH (2),
    .CONF_WIDTH (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cfg    (in_cfg),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cfg   (out_cfg),
    .out_a_mag (out_a_mag),
    .out_b_mag (out_b_mag),
    .out_neg   (out_neg),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: treat each group as one G*8-bit integer and take |x| mod 2^(G*8).
  function automatic void model(input logic [2:0] cfg, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, output logic [DW-1:0] ma,
                                output logic [DW-1:0] mb, output logic [NL-1:0] neg);
    int unsigned     gl, gw, ng;
    longint unsigned md, va, vb, xa, xb;
    bit              sa, sb, n;
    gl = (cfg[1:0] > 2'd2) ? 2 : 32'(cfg[1:0]);
    gw = LW << gl;
    ng = NL >> gl;
    md = 64'd1 << gw;
    ma = '0;
    mb = '0;
    neg = '0;
    for (int unsigned k = 0; k < ng; k++) begin
      va = (64'(a) >> (k * gw)) % md;
      vb = (64'(b) >> (k * gw)) % md;
      sa = cfg[2] && (va >= md / 2);
      sb = cfg[2] && (vb >= md / 2);
      xa = sa ? (md - va) % md : va;
      xb = sb ? (md - vb) % md : vb;
      n  = sa ^ sb;
`ifdef MAC_NEG_ZERO_SIGN_EN
      if (xa == 0 || xb == 0) n = 1'b0;
`endif
      ma = ma | 32'(xa << (k * gw));
      mb = mb | 32'(xb << (k * gw));
      for (int unsigned l = 0; l < NL; l++) begin
        if ((l >> gl) == k) neg[l] = n;
      end
    end
  endfunction

  function automatic logic [DW-1:0] rand_operand();
    logic [DW-1:0] v;
    for (int l = 0; l < NL; l++) begin
      case ($urandom_range(0, 4))
        0:       v[l*LW +: LW] = 8'h00;
        1:       v[l*LW +: LW] = 8'h80;
        2:       v[l*LW +: LW] = 8'hFF;
        3:       v[l*LW +: LW] = 8'h01;
        default: v[l*LW +: LW] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  typedef struct {
    logic [2:0]    cfg;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [NL-1:0] en;
  } vec_t;

  vec_t vecs[7];

  // Send one transaction with out_ready high and check the 2-cycle latency and the result.
  task automatic apply_vec(input logic [2:0] cfg, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                           input logic [NL-1:0] en, input int tag);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_cfg    = cfg;
    in_a      = a;
    in_b      = b;
    #1;
    check($sformatf("v%0d in_ready", tag), 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check($sformatf("v%0d out_valid early", tag), 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    check($sformatf("v%0d out_valid", tag), 64'(out_valid), 64'd1);
    check($sformatf("v%0d out_a_mag", tag), 64'(out_a_mag), 64'(ea));
    check($sformatf("v%0d out_b_mag", tag), 64'(out_b_mag), 64'(eb));
    check($sformatf("v%0d out_neg", tag), 64'(out_neg), 64'(en));
    check($sformatf("v%0d out_cfg", tag), 64'(out_cfg), 64'(cfg));
  endtask

  logic [2:0]    bp_cfg[4];
  logic [DW-1:0] bp_a[4];
  logic [DW-1:0] bp_b[4];
  logic [2:0]    q_c[$];
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  logic [NL-1:0] q_n[$];

  initial begin
    logic [DW-1:0] ma, mb, held_a;
    logic [NL-1:0] mn, held_n;
    int            idx, got, last_c;

    vecs[0] = '{3'b100, 32'h7F0180FB, 32'h00FEFF03, 32'h7F018005, 32'h00020103, 4'b0101};
    vecs[1] = '{3'b101, 32'h1234FF00, 32'h80000002, 32'h12340100, 32'h80000002, 4'b1111};
    vecs[2] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 4'b0000};
    vecs[3] = '{3'b000, 32'hFFFFFFFF, 32'h80808080, 32'hFFFFFFFF, 32'h80808080, 4'b0000};
    vecs[4] = '{3'b111, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'h00000003, 4'b1111};
    vecs[5] = '{3'b100, 32'h00000080, 32'h00000001, 32'h00000080, 32'h00000001, 4'b0001};
    vecs[6] = '{3'b001, 32'hFFFF8000, 32'h00017FFF, 32'hFFFF8000, 32'h00017FFF, 4'b0000};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_cfg    = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset out_neg", 64'(out_neg), 64'd0);
    check("reset out_cfg", 64'(out_cfg), 64'd0);
    check("reset out_a_mag", 64'(out_a_mag), 64'd0);
    check("reset out_b_mag", 64'(out_b_mag), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      apply_vec(vecs[i].cfg, vecs[i].a, vecs[i].b, vecs[i].ea, vecs[i].eb, vecs[i].en, i);
    end

    // Zero magnitude against a negative operand
`ifdef MAC_NEG_ZERO_SIGN_EN
    apply_vec(3'b100, 32'h00000000, 32'h000000FF, 32'h0, 32'h00000001, 4'b0000, 7);
`else
    apply_vec(3'b100, 32'h00000000, 32'h000000FF, 32'h0, 32'h00000001, 4'b0001, 7);
`endif

    // Backpressure: only two transactions fit while the output is stalled
    for (int k = 0; k < 4; k++) begin
      bp_cfg[k] = 3'($urandom);
      bp_a[k]   = rand_operand();
      bp_b[k]   = rand_operand();
    end
    idx    = 0;
    held_a = '0;
    held_n = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = (idx < 4);
      if (idx < 4) begin
        in_cfg = bp_cfg[idx];
        in_a   = bp_a[idx];
        in_b   = bp_b[idx];
      end
      #1;
      if (in_valid && in_ready) idx++;
      if (c == 2) begin
        held_a = out_a_mag;
        held_n = out_neg;
      end
    end
    check("bp accepts", 64'(idx), 64'd2);
    check("bp in_ready", 64'(in_ready), 64'd0);
    check("bp busy", 64'(busy), 64'd1);
    check("bp out_valid", 64'(out_valid), 64'd1);
    check("bp hold a_mag", 64'(out_a_mag), 64'(held_a));
    check("bp hold neg", 64'(out_neg), 64'(held_n));
    got    = 0;
    last_c = -1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (idx < 4);
      if (idx < 4) begin
        in_cfg = bp_cfg[idx];
        in_a   = bp_a[idx];
        in_b   = bp_b[idx];
      end
      #1;
      if (out_valid) begin
        model(bp_cfg[got], bp_a[got], bp_b[got], ma, mb, mn);
        check($sformatf("bp out%0d a_mag", got), 64'(out_a_mag), 64'(ma));
        check($sformatf("bp out%0d b_mag", got), 64'(out_b_mag), 64'(mb));
        check($sformatf("bp out%0d neg", got), 64'(out_neg), 64'(mn));
        check($sformatf("bp out%0d cfg", got), 64'(out_cfg), 64'(bp_cfg[got]));
        got++;
        last_c = c;
      end
      if (in_valid && in_ready) idx++;
    end
    check("bp outputs", 64'(got), 64'd4);
    check("bp back-to-back", 64'(last_c), 64'd3);

    // Reset while both stages hold data
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_cfg    = 3'b100;
    in_a      = 32'h000000FF;
    in_b      = 32'h00000001;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre-reset busy", 64'(busy), 64'd1);
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid reset out_valid", 64'(out_valid), 64'd0);
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset out_a_mag", 64'(out_a_mag), 64'd0);
    check("mid reset out_neg", 64'(out_neg), 64'd0);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    check("after reset in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("no stale output c%0d", c), 64'(out_valid), 64'd0);
    end

    // Random traffic with random backpressure against the scoreboard
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_cfg    = 3'($urandom);
      in_a      = rand_operand();
      in_b      = rand_operand();
      #1;
      if (out_valid && out_ready) begin
        if (q_a.size() == 0) begin
          check("rand unexpected output", 64'd1, 64'd0);
        end else begin
          check("rand a_mag", 64'(out_a_mag), 64'(q_a.pop_front()));
          check("rand b_mag", 64'(out_b_mag), 64'(q_b.pop_front()));
          check("rand neg", 64'(out_neg), 64'(q_n.pop_front()));
          check("rand cfg", 64'(out_cfg), 64'(q_c.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        model(in_cfg, in_a, in_b, ma, mb, mn);
        q_a.push_back(ma);
        q_b.push_back(mb);
        q_n.push_back(mn);
        q_c.push_back(in_cfg);
      end
    end
    for (int c = 0; c < 10 && q_a.size() > 0; c++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        check("drain a_mag", 64'(out_a_mag), 64'(q_a.pop_front()));
        check("drain b_mag", 64'(out_b_mag), 64'(q_b.pop_front()));
        check("drain neg", 64'(out_neg), 64'(q_n.pop_front()));
        check("drain cfg", 64'(out_cfg), 64'(q_c.pop_front()));
      end
    end
    check("rand all delivered", 64'(q_a.size()), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("final busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_operand_sign_pipe.md
Name: mac_operand_sign_pipe

Overview:
- Pipelined operand pre-conditioner at the front of the MAC array.
- Takes NUM_LANES packed A/B operand lanes and a per-transaction config. Under the configured lane grouping (single/dual/quad/... lanes per operand) it converts signed groups to unsigned magnitude, and emits a per-lane product-sign flag for the result re-negation stage.
- Valid/ready on both sides; config travels with its data.

Parameters:
- NUM_LANES, 4, number of minimum-width lanes; power of 2, >= 2.
- LANE_WIDTH, 8, bits per lane.
- MODE_WIDTH, 2, width of group-size field; must satisfy 2^MODE_WIDTH > log2(NUM_LANES).
- CONF_WIDTH, MODE_WIDTH+1, config width: MSB = signed, low MODE_WIDTH bits = log2(lanes per group).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input.
- in_cfg  in  CONF_WIDTH  config for this transaction.
- in_a  in  NUM_LANES*LANE_WIDTH  packed A lanes, lane 0 at LSBs.
- in_b  in  NUM_LANES*LANE_WIDTH  packed B lanes.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts output.
- out_cfg  out  CONF_WIDTH  config carried with the output data.
- out_a_mag  out  NUM_LANES*LANE_WIDTH  unsigned magnitude of A groups.
- out_b_mag  out  NUM_LANES*LANE_WIDTH  unsigned magnitude of B groups.
- out_neg  out  NUM_LANES  product-negative flag, replicated across all lanes of a group.
- busy  out  1  any pipeline stage holds valid data.

Behaviour:
- Reset (rst low, async):
  - s1_valid, s2_valid, out_valid, busy, out_neg, out_cfg, out_a_mag and out_b_mag all clear to 0.
  - in_ready = 1 once rst is high.
- Group size G = 2^min(cfg[MODE_WIDTH-1:0], log2(NUM_LANES)). Mode values above the maximum clamp to all lanes in one group.
- Groups are aligned: lanes [k*G, k*G+G-1].
- Stage 1 (register): on in_valid & in_ready, capture a, b, cfg.
  - Compute per-group signA/signB = cfg signed bit AND the MSB of the group's top lane; 0 when unsigned.
- Stage 2 (register):
  - Conditional two's complement per group. Each lane inverts and adds carry-in.
  - Lane 0 of each group takes carry-in 1. Inner lanes take the carry-out of the lane below. Carry never crosses a group boundary.
  - A lane is negated only if its group sign is 1.
  - out_neg for all lanes of a group = signA XOR signB.
- The most-negative value, e.g. 0x80 at G=1, yields magnitude 0x80, read as unsigned. No overflow flag.
- Handshake:
  - s2_ready = ~s2_valid | out_ready.
  - in_ready = ~s1_valid | s2_ready, combinational from out_ready.
  - Stage-to-stage moves happen only when the downstream stage is ready. A stalled stage holds its data and cfg stable.
  - out_* are stable while out_valid & ~out_ready.
- Latency 2 cycles from accept to out_valid with out_ready held high. Throughput 1 transaction/cycle.
- Order is preserved. Nothing is dropped or duplicated.
- Simultaneous accept and emit in the same cycle is legal and keeps full throughput.
- cfg may change on every transaction. Each output uses only its own captured cfg.
- busy = s1_valid | s2_valid.
- Reset mid-operation discards all in-flight data. No partial output appears after reset.

Optional Feature:
- Macro: MAC_NEG_ZERO_SIGN_EN.
- Defined: out_neg for a group is forced to 0 when either group magnitude is zero, so the result stage never produces negative zero. The zero detect is done in stage 2 on the final magnitude.
- Not defined: out_neg = signA XOR signB unconditionally.

Test Plan:
- Single, signed (cfg=0b100), lane0 A=0xFB, B=0x03, out_ready=1 -> after 2 cycles lane0 out_a_mag=0x05, out_b_mag=0x03, out_neg[0]=1; other lanes follow their own signs.
- Dual, signed (cfg=0b101), A[15:0]=0xFF00, B[15:0]=0x0002 -> out_a_mag[15:0]=0x0100, out_b_mag[15:0]=0x0002, out_neg[1:0]=2'b11. A carry is generated inside the group but does not reach lane 2.
- Quad, signed (cfg=0b110), A=0x80000000, B=0xFFFFFFFF -> out_a_mag=0x80000000, out_b_mag=0x00000001, out_neg=4'b0000.
- Unsigned single (cfg=0b000), A=0xFFFFFFFF, B=0x80808080 -> magnitudes equal the inputs, out_neg=0. Mode value 3 with NUM_LANES=4 behaves as quad.
- Backpressure: issue 4 back-to-back transactions with out_ready=0 -> in_ready falls after 2 accepts and outputs hold stable. Release out_ready -> 4 outputs appear in issue order, one per cycle, none lost.
- Reset while busy=1 and out_valid=1 -> out_valid and busy fall immediately on rst low. After release in_ready=1 and no stale output appears. With MAC_NEG_ZERO_SIGN_EN, A=0x00, B=0xFF single signed -> out_neg[0]=0.
